shot_clock_ctrl: RTL and testbench

- Sequencing controller for the 24-second countdown display path.
- Owns the run/pause/expire state machine, an internal half-second/one-second prescaler, BCD countdown registers, and the post-expiry LED flash/buzzer sequence.
- Inputs are debounced single-cycle button pulses on clk.
- Outputs {code1,code0} feed seg_scan directly, and led drives the board LED.

---
 rtl/shot_clock_ctrl.sv | 156 +++++++++++++++
 tb/tb_shot_clock_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/shot_clock_ctrl.sv
// Shot-clock sequencer: run/pause/expire FSM, half-second prescaler, BCD
// countdown and post-expiry LED flash / buzzer sequence.
module shot_clock_ctrl #(
   parameter int HALF_SEC_CYCLES = 25000000,
   parameter int FULL_SEC        = 24,
   parameter int SHORT_SEC       = 14,
   parameter int FLASH_TOGGLES   = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_pulse,
   input  logic       pause_pulse,
   input  logic       reload_full,
   input  logic       reload_short,
   output logic [3:0] code1,
   output logic [3:0] code0,
   output logic       running,
   output logic       expired,
   output logic       led,
   output logic       buzzer
);

   localparam int PW = (HALF_SEC_CYCLES > 2) ? $clog2(HALF_SEC_CYCLES) : 1;
   localparam logic [PW-1:0] PRE_TOP    = PW'(HALF_SEC_CYCLES - 1);
   localparam logic [3:0]    FULL_TENS  = 4'(FULL_SEC / 10);
   localparam logic [3:0]    FULL_UNITS = 4'(FULL_SEC % 10);
   localparam logic [3:0]    SHORT_TENS  = 4'(SHORT_SEC / 10);
   localparam logic [3:0]    SHORT_UNITS = 4'(SHORT_SEC % 10);
   localparam logic [3:0]    FLASH_LAST = 4'(FLASH_TOGGLES);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSE   = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   state_t          state, state_n;
   logic [PW-1:0]   pre_cnt, pre_cnt_n;
   logic            half_phase, half_phase_n;
   logic [3:0]      code1_n, code0_n;
   logic [3:0]      flash_cnt, flash_cnt_n;
   logic            led_n, buzzer_n;
   logic            counting, half_tick, sec_tick, reload;

   // NOTE: every variable gets its default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_n      = state;
      pre_cnt_n    = pre_cnt;
      half_phase_n = half_phase;
      code1_n      = code1;
      code0_n      = code0;
      flash_cnt_n  = flash_cnt;
      led_n        = led;
      buzzer_n     = buzzer;

      counting  = (state == RUN) || (state == EXPIRED);
      half_tick = counting && (pre_cnt == PRE_TOP);
      sec_tick  = half_tick && half_phase;
      reload    = reload_full || reload_short;

      if (counting) begin
         if (half_tick) begin
            pre_cnt_n    = '0;
            half_phase_n = ~half_phase;
         end else begin
            pre_cnt_n = pre_cnt + PW'(1);
         end
      end

      case (state)
         IDLE: begin
            if (start_pulse) begin
               state_n      = RUN;
               pre_cnt_n    = '0;
               half_phase_n = 1'b0;
            end
         end
         PAUSE: begin
            if (start_pulse) state_n = RUN;
         end
         RUN: begin
            if (pause_pulse) begin
               state_n = PAUSE;
            end else if (sec_tick) begin
               if (code0 != 4'd0) begin
                  code0_n = code0 - 4'd1;
               end else if (code1 != 4'd0) begin
                  code1_n = code1 - 4'd1;
                  code0_n = 4'd9;
               end
               if (code1 == 4'd0 && code0 == 4'd1) begin
                  state_n     = EXPIRED;
                  buzzer_n    = 1'b1;
                  flash_cnt_n = 4'd0;
               end
            end
         end
         EXPIRED: begin
            if (flash_cnt == FLASH_LAST) begin
               led_n    = 1'b1;
               buzzer_n = 1'b0;
            end else if (half_tick) begin
               led_n       = ~led;
               flash_cnt_n = flash_cnt + 4'd1;
            end
         end
         default: state_n = IDLE;
      endcase

      // A reload outranks pause/start and any decrement in the same cycle.
      if (reload) begin
         code1_n      = reload_full ? FULL_TENS  : SHORT_TENS;
         code0_n      = reload_full ? FULL_UNITS : SHORT_UNITS;
         pre_cnt_n    = '0;
         half_phase_n = 1'b0;
         if (state == EXPIRED) begin
            state_n     = IDLE;
            flash_cnt_n = 4'd0;
            buzzer_n    = 1'b0;
         end else begin
            state_n = state;
         end
      end

      if (state_n != EXPIRED) led_n = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pre_cnt    <= '0;
         half_phase <= 1'b0;
         code1      <= FULL_TENS;
         code0      <= FULL_UNITS;
         flash_cnt  <= 4'd0;
         led        <= 1'b1;
         buzzer     <= 1'b0;
         running    <= 1'b0;
         expired    <= 1'b0;
      end else begin
         state      <= state_n;
         pre_cnt    <= pre_cnt_n;
         half_phase <= half_phase_n;
         code1      <= code1_n;
         code0      <= code0_n;
         flash_cnt  <= flash_cnt_n;
         led        <= led_n;
         buzzer     <= buzzer_n;
         running    <= (state_n == RUN);
         expired    <= (state_n == EXPIRED);
      end
   end

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// Directed bench for shot_clock_ctrl with a 4-cycle half second so a full
// count-down and flash sequence fit in a few hundred cycles.
module tb_shot_clock_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_pulse, pause_pulse, reload_full, reload_short;
   logic [3:0] code1, code0;
   logic       running, expired, led, buzzer;

   int checks = 0;
   int errors = 0;

   shot_clock_ctrl #(
      .HALF_SEC_CYCLES(4),
      .FULL_SEC       (24),
      .SHORT_SEC      (14),
      .FLASH_TOGGLES  (6)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start_pulse (start_pulse),
      .pause_pulse (pause_pulse),
      .reload_full (reload_full),
      .reload_short(reload_short),
      .code1       (code1),
      .code0       (code0),
      .running     (running),
      .expired     (expired),
      .led         (led),
      .buzzer      (buzzer)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled there as well.
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // sel: [0] start, [1] pause, [2] reload_short, [3] reload_full
   task automatic pulse(input logic [3:0] sel);
      start_pulse  = sel[0];
      pause_pulse  = sel[1];
      reload_short = sel[2];
      reload_full  = sel[3];
      step(1);
      {reload_full, reload_short, pause_pulse, start_pulse} = 4'b0;
   endtask

   function automatic logic [7:0] code();
      return {code1, code0};
   endfunction

   initial begin
      #100us;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      {reload_full, reload_short, pause_pulse, start_pulse} = 4'b0;
      step(2);
      rst = 1'b0;
      check("rst_code",    code(),  8'h24);
      check("rst_running", running, 1'b0);
      check("rst_expired", expired, 1'b0);
      check("rst_led",     led,     1'b1);
      check("rst_buzzer",  buzzer,  1'b0);

      // Test 1: first decrement exactly 8 cycles after RUN entry; start in RUN ignored.
      pulse(4'b0001);
      check("t1_running", running, 1'b1);
      check("t1_code_s0", code(), 8'h24);
      step(3);
      pulse(4'b0001);
      step(3);
      check("t1_code_s7", code(), 8'h24);
      step(1);
      check("t1_code_s8", code(), 8'h23);
      step(24);
      check("t1_code_20", code(), 8'h20);
      step(8);
      check("t1_code_19", code(), 8'h19);

      // Test 2: expiry and flash sequence.
      step(144);
      check("t2_code_01", code(), 8'h01);
      check("t2_run_01",  running, 1'b1);
      step(8);
      check("t2_code_00", code(), 8'h00);
      check("t2_expired", expired, 1'b1);
      check("t2_buzzer",  buzzer, 1'b1);
      check("t2_not_run", running, 1'b0);
      check("t2_led_x0",  led, 1'b1);
      step(3);
      check("t2_led_x3",  led, 1'b1);
      step(1);
      check("t2_led_x4",  led, 1'b0);
      step(4);
      check("t2_led_x8",  led, 1'b1);
      step(12);
      check("t2_led_x20", led, 1'b0);
      check("t2_buz_x20", buzzer, 1'b1);
      step(10);
      check("t2_led_end", led, 1'b1);
      check("t2_buz_end", buzzer, 1'b0);
      pulse(4'b0001);
      step(40);
      check("t2_hold_code", code(), 8'h00);
      check("t2_hold_exp",  expired, 1'b1);
      check("t2_hold_led",  led, 1'b1);
      check("t2_hold_buz",  buzzer, 1'b0);

      // Reload from EXPIRED returns to IDLE.
      pulse(4'b0100);
      check("rl_code",    code(), 8'h14);
      check("rl_expired", expired, 1'b0);
      check("rl_running", running, 1'b0);

      // Test 3: pause 3 cycles into a second, resume keeps the fraction.
      pulse(4'b0001);
      step(2);
      pulse(4'b0010);
      check("t3_paused", running, 1'b0);
      step(50);
      check("t3_frozen", code(), 8'h14);
      pulse(4'b0001);
      check("t3_resumed", running, 1'b1);
      step(4);
      check("t3_code_r4", code(), 8'h14);
      step(1);
      check("t3_code_r5", code(), 8'h13);

      // Test 4: reloads in RUN, reload vs sec_tick, pause vs sec_tick.
      step(48);
      check("t4_code_07", code(), 8'h07);
      step(3);
      pulse(4'b0100);
      check("t4_short",     code(), 8'h14);
      check("t4_short_run", running, 1'b1);
      step(7);
      check("t4_code_l7", code(), 8'h14);
      step(1);
      check("t4_code_l8", code(), 8'h13);
      pulse(4'b1100);
      check("t4_both", code(), 8'h24);
      step(7);
      pulse(4'b0100);
      check("t4_reload_tick", code(), 8'h14);
      check("t4_reload_run",  running, 1'b1);
      step(7);
      pulse(4'b0010);
      check("t4_pause_tick", code(), 8'h14);
      check("t4_pause_run",  running, 1'b0);

      // Test 5: reload mid-flash.
      pulse(4'b0001);
      step(112);
      check("t5_expired", expired, 1'b1);
      step(6);
      check("t5_led_mid", led, 1'b0);
      check("t5_buz_mid", buzzer, 1'b1);
      pulse(4'b1000);
      check("t5_code",    code(), 8'h24);
      check("t5_led",     led, 1'b1);
      check("t5_buzzer",  buzzer, 1'b0);
      check("t5_expired0", expired, 1'b0);
      check("t5_running0", running, 1'b0);
      pulse(4'b0001);
      step(8);
      check("t5_count", code(), 8'h23);

      // Test 6: reset during RUN together with start.
      step(88);
      check("t6_code_12", code(), 8'h12);
      rst         = 1'b1;
      start_pulse = 1'b1;
      step(1);
      rst         = 1'b0;
      start_pulse = 1'b0;
      check("t6_code",    code(), 8'h24);
      check("t6_running", running, 1'b0);
      check("t6_led",     led, 1'b1);
      check("t6_buzzer",  buzzer, 1'b0);
      step(10);
      check("t6_idle_code", code(), 8'h24);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
